mem_access_ctrl: RTL

//  Sequences every load/store from the multicycle datapath onto the 16-bit data memory.
//  - Accepts a one-cycle request and latches address, direction and write data.
//  - Range-checks the address, then drives memRead/memWrite/adr/writeData for the correct number of cycles.
//  - Captures read data into a memory data register (MDR) and returns a one-cycle done pulse.

---
 rtl/mem_access_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the multicycle datapath and the 16-bit data memory.
// Latches one request, range-checks it, drives the memory strobes and returns a done pulse.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [DATA_W-1:0] rdata,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAdr,
    output logic [DATA_W-1:0] memWriteData,
    input  logic [DATA_W-1:0] memData
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StFlt,
        StDone
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               addr_bad;

    // Full-width compare so upper address bits can never alias into range.
    assign addr_bad = 32'(addr) >= MEM_DEPTH;

    // Strobes are registered alongside the state so they mirror it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= StIdle;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
            rdata        <= '0;
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
            memAdr       <= '0;
            memWriteData <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req) begin
                        memAdr       <= addr;
                        memWriteData <= wdata;
                        fault        <= 1'b0;
                        busy         <= 1'b1;
                        if (addr_bad) begin
                            state <= StFlt;
                        end else if (we) begin
                            state    <= StWrite;
                            memWrite <= 1'b1;
                        end else begin
                            state   <= StRead;
                            memRead <= 1'b1;
                            cnt     <= CNT_W'(RD_LAT - 1);
                        end
                    end
                end
                StWrite: begin
                    memWrite <= 1'b0;
                    done     <= 1'b1;
                    state    <= StDone;
                end
                StRead: begin
                    if (cnt == '0) begin
                        rdata   <= memData;
                        memRead <= 1'b0;
                        done    <= 1'b1;
                        state   <= StDone;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StFlt: begin
                    fault <= 1'b1;
                    done  <= 1'b1;
                    state <= StDone;
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
